qdec_ctx_ctrl: RTL and testbench

QDEC_CTX_CTRL -- requirements
Module: qdec_ctx_ctrl

---
 rtl/qdec_cabac_pkg.sv | 25 ++
 rtl/qdec_ctx_init_calc.sv | 35 +++
 rtl/qdec_ctx_ctrl.sv | 100 ++++++++++
 tb/tb_qdec_ctx_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_cabac_pkg.sv
// Shared types and helpers for the CABAC context-initialisation controller.
package qdec_cabac_pkg;

  localparam logic [9:0] DEF_NUM_CTX = 10'd512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_DONE
  } ctx_state_t;

  typedef struct packed {
    logic       pad;
    logic [5:0] p_state;
    logic       val_mps;
  } ctx_entry_t;

  // SliceQpY is signed; contexts are only defined for luma QP 0..51.
  function automatic logic [5:0] clip_qp(input logic signed [6:0] qp);
    if (qp < 7'sd0)       return 6'd0;
    else if (qp > 7'sd51) return 6'd51;
    else                  return qp[5:0];
  endfunction

endpackage

// File: rtl/qdec_ctx_init_calc.sv
// Combinational initValue/QP to context-entry mapping (CABAC state init).
module qdec_ctx_init_calc
  import qdec_cabac_pkg::*;
(
  input  logic [7:0] init_value,
  input  logic [5:0] qpc,
  output logic [7:0] entry
);

  logic signed [12:0] slope;
  logic signed [12:0] offset;
  logic signed [12:0] prod;
  logic signed [12:0] pre_raw;
  logic [6:0]         pre;
  ctx_entry_t         ent;

  always_comb begin
    // NOTE: every variable gets a value on every path, so no latch is inferred.
    slope   = $signed({9'd0, init_value[7:4]}) * 13'sd5 - 13'sd45;
    offset  = $signed({6'd0, init_value[3:0], 3'b000}) - 13'sd16;
    prod    = slope * $signed({7'd0, qpc});
    pre_raw = (prod >>> 4) + offset;

    if (pre_raw < 13'sd1)        pre = 7'd1;
    else if (pre_raw > 13'sd126) pre = 7'd126;
    else                         pre = pre_raw[6:0];

    ent.pad     = 1'b0;
    ent.val_mps = (pre > 7'd63);
    ent.p_state = ent.val_mps ? 6'(pre - 7'd64) : 6'(7'd63 - pre);
  end

  assign entry = ent;

endmodule

// File: rtl/qdec_ctx_ctrl.sv
// Context-memory controller: fills the context RAM from the initValue ROM
// at slice start and otherwise arbitrates decoder accesses to that RAM.
module qdec_ctx_ctrl
  import qdec_cabac_pkg::*;
#(
  parameter logic [9:0] NUM_CTX = DEF_NUM_CTX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  input  logic signed [6:0] slice_qp,
  output logic              init_busy,
  output logic              init_done,
  output logic [9:0]        tbl_addr,
  input  logic [7:0]        tbl_rdata,
  input  logic              dec_req,
  input  logic              dec_we,
  input  logic [9:0]        dec_addr,
  input  logic [7:0]        dec_wdata,
  output logic              dec_gnt,
  output logic [7:0]        dec_rdata,
  output logic              dec_rvalid,
  output logic [9:0]        ctx_addr,
  output logic [7:0]        ctx_wdata,
  output logic              ctx_we,
  output logic              ctx_re,
  input  logic [7:0]        ctx_rdata
);

  ctx_state_t state_q, state_d;
  logic [9:0] rd_idx;
  logic [5:0] qpc_q;
  logic       rvalid_q;
  logic       init_wr;
  logic [7:0] entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rd_idx   <= '0;
      qpc_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      if (state_q == ST_IDLE && init_start)
        qpc_q <= clip_qp(slice_qp);
      rd_idx   <= (state_q == ST_INIT && rd_idx != NUM_CTX) ? rd_idx + 10'd1 : '0;
      rvalid_q <= dec_gnt & ~dec_we;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (init_start) state_d = ST_INIT;
      ST_INIT: if (rd_idx == NUM_CTX) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  qdec_ctx_init_calc u_calc (
    .init_value (tbl_rdata),
    .qpc        (qpc_q),
    .entry      (entry)
  );

  // Write phase lags the ROM read by one cycle: INIT cycle k+1 writes entry k.
  assign init_wr = (state_q == ST_INIT) && (rd_idx != '0);

  // Grant is combinational from dec_req, so it must be gated by reset directly.
  assign dec_gnt = rst_n && (state_q == ST_IDLE) && !init_start && dec_req;

  always_comb begin
    tbl_addr  = '0;
    ctx_addr  = '0;
    ctx_wdata = '0;
    ctx_we    = 1'b0;
    ctx_re    = 1'b0;
    if (state_q == ST_INIT)
      tbl_addr = (rd_idx == NUM_CTX) ? NUM_CTX - 10'd1 : rd_idx;
    if (init_wr) begin
      ctx_addr  = rd_idx - 10'd1;
      ctx_wdata = entry;
      ctx_we    = 1'b1;
    end else if (dec_gnt) begin
      ctx_addr  = dec_addr;
      ctx_wdata = dec_wdata;
      ctx_we    = dec_we;
      ctx_re    = ~dec_we;
    end
  end

  assign init_busy  = (state_q != ST_IDLE);
  assign init_done  = (state_q == ST_DONE);
  assign dec_rvalid = rvalid_q;
  assign dec_rdata  = rvalid_q ? ctx_rdata : '0;

endmodule

// File: tb/tb_qdec_ctx_ctrl.sv
// Scoreboard bench for qdec_ctx_ctrl with a 4-entry ROM and a context RAM model.
module tb_qdec_ctx_ctrl;

  logic              clk;
  logic              rst_n;
  logic              init_start;
  logic signed [6:0] slice_qp;
  logic              init_busy, init_done;
  logic [9:0]        tbl_addr;
  logic [7:0]        tbl_rdata;
  logic              dec_req, dec_we;
  logic [9:0]        dec_addr;
  logic [7:0]        dec_wdata;
  logic              dec_gnt;
  logic [7:0]        dec_rdata;
  logic              dec_rvalid;
  logic [9:0]        ctx_addr;
  logic [7:0]        ctx_wdata;
  logic              ctx_we, ctx_re;
  logic [7:0]        ctx_rdata;

  int checks = 0;
  int errors = 0;

  logic [17:0] sb_wr[$];  // {addr, data} expected on ctx write port
  logic [7:0]  sb_rd[$];  // expected dec_rdata

  logic [7:0] rom [4];
  logic [7:0] mem [1024];

  // Hand-computed entries for ROM {154, 139, 0, 255}; index 0 is the LSB byte.
  localparam logic [3:0][7:0] EXP_QP26 = {8'h7D, 8'h7C, 8'h00, 8'h01};
  localparam logic [3:0][7:0] EXP_QP51 = {8'h7D, 8'h7C, 8'h0E, 8'h01};
  localparam logic [3:0][7:0] EXP_QP0  = {8'h51, 8'h7C, 8'h11, 8'h01};

  qdec_ctx_ctrl #(.NUM_CTX(10'd4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .slice_qp   (slice_qp),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .tbl_addr   (tbl_addr),
    .tbl_rdata  (tbl_rdata),
    .dec_req    (dec_req),
    .dec_we     (dec_we),
    .dec_addr   (dec_addr),
    .dec_wdata  (dec_wdata),
    .dec_gnt    (dec_gnt),
    .dec_rdata  (dec_rdata),
    .dec_rvalid (dec_rvalid),
    .ctx_addr   (ctx_addr),
    .ctx_wdata  (ctx_wdata),
    .ctx_we     (ctx_we),
    .ctx_re     (ctx_re),
    .ctx_rdata  (ctx_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rom[0] = 8'd154; rom[1] = 8'd139; rom[2] = 8'd0; rom[3] = 8'd255;
  end

  always @(posedge clk) begin
    tbl_rdata <= (tbl_addr < 10'd4) ? rom[tbl_addr[1:0]] : 8'h00;
    if (ctx_we) mem[ctx_addr] <= ctx_wdata;
    if (ctx_re) ctx_rdata <= mem[ctx_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every read response is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ctx_we) begin
        if (sb_wr.size() == 0) check("wr_unexpected", ctx_we, 1'b0);
        else begin
          logic [17:0] e;
          e = sb_wr.pop_front();
          check("wr_addr", ctx_addr, e[17:8]);
          check("wr_data", ctx_wdata, e[7:0]);
        end
      end
      if (dec_rvalid) begin
        if (sb_rd.size() == 0) check("rd_unexpected", dec_rvalid, 1'b0);
        else check("rd_data", dec_rdata, sb_rd.pop_front());
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_busy",   init_busy,  1'b0);
    check("rst_done",   init_done,  1'b0);
    check("rst_gnt",    dec_gnt,    1'b0);
    check("rst_rvalid", dec_rvalid, 1'b0);
    check("rst_we",     ctx_we,     1'b0);
    check("rst_re",     ctx_re,     1'b0);
    check("rst_tbl",    tbl_addr,   10'd0);
    check("rst_caddr",  ctx_addr,   10'd0);
    check("rst_cwdata", ctx_wdata,  8'd0);
    check("rst_rdata",  dec_rdata,  8'd0);
  endtask

  // One initialisation; optionally hold dec_req, re-pulse init_start mid-INIT,
  // or return at the DONE cycle so the next call starts back-to-back.
  task automatic run_init(input logic signed [6:0] qp, input logic [3:0][7:0] exp,
                          input bit hold_req, input bit restart_mid, input bit chain);
    int busy_n = 0, done_n = 0, we_n = 0, gnt_n = 0, first_we = -1, last_we = -1;
    @(posedge clk); #1;
    init_start = 1'b1; slice_qp = qp;
    dec_req = hold_req; dec_we = 1'b0; dec_addr = 10'd2;
    for (int i = 0; i < 4; i++) sb_wr.push_back({10'(i), exp[i]});
    @(negedge clk);
    check("gnt_at_start", dec_gnt, 1'b0);
    @(posedge clk); #1;
    init_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!init_busy) break;
      busy_n++;
      if (ctx_we) begin
        if (first_we < 0) first_we = c;
        last_we = c;
        we_n++;
      end
      gnt_n  += int'(dec_gnt);
      done_n += int'(init_done);
      init_start = restart_mid && (c == 2);
      if (chain && init_done) break;
    end
    init_start = 1'b0;
    check("busy_cycles", busy_n, 6);
    check("done_pulses", done_n, 1);
    check("we_count", we_n, 4);
    check("we_span", last_we - first_we, 3);
    check("gnt_while_busy", gnt_n, 0);
    if (!chain) begin
      check("gnt_after_done", dec_gnt, hold_req);
      if (dec_gnt) sb_rd.push_back(exp[2]);
      @(posedge clk); #1;
      dec_req = 1'b0;
      @(negedge clk);
      check("rvalid_after_grant", dec_rvalid, hold_req);
    end
  endtask

  task automatic dec_op(input bit we, input logic [9:0] addr, input logic [7:0] wdata,
                        input logic [7:0] exp_rd);
    @(posedge clk); #1;
    dec_req = 1'b1; dec_we = we; dec_addr = addr; dec_wdata = wdata;
    if (we) sb_wr.push_back({addr, wdata});
    else    sb_rd.push_back(exp_rd);
    @(negedge clk);
    check("dec_gnt", dec_gnt, 1'b1);
    check("dec_ctx_re", ctx_re, !we);
    @(posedge clk); #1;
    dec_req = 1'b0;
    @(negedge clk);
    check("dec_rvalid", dec_rvalid, !we);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; init_start = 1'b0; slice_qp = '0;
    dec_req = 1'b1; dec_we = 1'b0; dec_addr = 10'd7; dec_wdata = 8'hA5;
    #12;
    check_reset_outputs();
    #5;
    rst_n = 1'b1; dec_req = 1'b0;

    run_init(7'sd26, EXP_QP26, 1'b0, 1'b0, 1'b0);
    dec_op(1'b1, 10'd5, 8'h3C, 8'h00);
    dec_op(1'b0, 10'd5, 8'h00, 8'h3C);
    dec_op(1'b0, 10'd1, 8'h00, 8'h00);

    run_init(7'sd51, EXP_QP51, 1'b1, 1'b1, 1'b1);
    run_init(7'sd60, EXP_QP51, 1'b0, 1'b0, 1'b0);
    run_init(-7'sd10, EXP_QP0, 1'b1, 1'b0, 1'b0);

    // Reset during the second of four writes, then a full re-initialisation.
    @(posedge clk); #1;
    init_start = 1'b1; slice_qp = 7'sd26;
    for (int i = 0; i < 4; i++) sb_wr.push_back({10'(i), EXP_QP26[i]});
    @(posedge clk); #1;
    init_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ctx_we && ctx_addr == 10'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_wait_found", found, 1'b1);
    #2;
    rst_n = 1'b0; dec_req = 1'b1;
    #1;
    check_reset_outputs();
    sb_wr.delete();
    @(posedge clk); #2;
    rst_n = 1'b1; dec_req = 1'b0;
    run_init(7'sd26, EXP_QP26, 1'b0, 1'b0, 1'b0);
    dec_op(1'b0, 10'd3, 8'h00, 8'h7D);

    repeat (2) @(negedge clk);
    check("sb_wr_empty", sb_wr.size(), 0);
    check("sb_rd_empty", sb_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
